// File: rtl/whack_pkg.sv
// Shared constants and arithmetic helpers for the whack-a-mole scorer.
package whack_pkg;

   // Default counter width for score, miss and escape counters.
   localparam int DEFAULT_SCORE_WIDTH = 10;

   // Widest hole vector the popcount helper accepts, and its result width.
   localparam int MAX_HOLES = 64;
   localparam int PC_W      = 7;

   // Number of set bits in a hole vector; callers zero-extend to MAX_HOLES.
   function automatic logic [PC_W-1:0] popcount(input logic [MAX_HOLES-1:0] v);
      logic [PC_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < MAX_HOLES; i++) begin
         cnt = cnt + PC_W'(v[i]);
      end
      return cnt;
   endfunction

   // cur + add - sub, clamped to [0, max_val]; operands stay small, so int is wide enough.
   function automatic int sat_add_sub(input int cur, input int add, input int sub,
                                      input int max_val);
      int tmp;
      tmp = cur + add - sub;
      if (tmp < 0) begin
         tmp = 0;
      end else if (tmp > max_val) begin
         tmp = max_val;
      end
      return tmp;
   endfunction

endpackage

// File: rtl/button_debouncer.sv
// One hole's button path: 2-flop synchronizer, debouncer, rising-edge press detect.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic button,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic          sync_1;
   logic          sync_2;
   logic          db;
   logic          db_prev;
   logic [CW-1:0] cnt;

   // Synchronize the raw button and flip db after DEBOUNCE_CYCLES disagreeing samples.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_1  <= 1'b0;
         sync_2  <= 1'b0;
         db      <= 1'b0;
         db_prev <= 1'b0;
         cnt     <= '0;
      end else begin
         sync_1  <= button;
         sync_2  <= sync_1;
         db_prev <= db;
         if (sync_2 != db) begin
            if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
               db  <= sync_2;
               cnt <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   // A press is the debounced rising edge; releases produce nothing.
   assign press = db & ~db_prev;

endmodule

// File: rtl/whack_scorer.sv
// Round detection, hit mask and saturating score/miss/escape counters.
module whack_scorer
   import whack_pkg::*;
#(
   parameter int NUM_HOLES       = 18,
   parameter int SCORE_WIDTH     = DEFAULT_SCORE_WIDTH,
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int MISS_PENALTY    = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_HOLES-1:0]   mole_positions,
   input  logic [NUM_HOLES-1:0]   buttons,
   input  logic                   game_enable,
   input  logic                   score_clear,
   output logic [NUM_HOLES-1:0]   visible_moles,
   output logic [SCORE_WIDTH-1:0] score,
   output logic [SCORE_WIDTH-1:0] miss_count,
   output logic [SCORE_WIDTH-1:0] escaped_count,
   output logic                   hit_pulse,
   output logic                   miss_pulse
);

   localparam int MAX_VAL = (1 << SCORE_WIDTH) - 1;

   logic [NUM_HOLES-1:0]   press;
   logic [NUM_HOLES-1:0]   mole_prev;
   logic [NUM_HOLES-1:0]   hit_mask;
   logic [NUM_HOLES-1:0]   hit_mask_next;
   logic [NUM_HOLES-1:0]   visible_now;
   logic [NUM_HOLES-1:0]   hits;
   logic [NUM_HOLES-1:0]   misses;
   logic                   round_start;
   logic                   round_end;
   logic [PC_W-1:0]        hit_cnt;
   logic [PC_W-1:0]        miss_cnt;
   logic [PC_W-1:0]        esc_cnt;
   logic [SCORE_WIDTH-1:0] score_next;
   logic [SCORE_WIDTH-1:0] miss_next;
   logic [SCORE_WIDTH-1:0] esc_next;

   genvar g;
   generate
      for (g = 0; g < NUM_HOLES; g++) begin : g_btn
         button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .button(buttons[g]),
            .press (press[g])
         );
      end
   endgenerate

   // Classify presses against the currently visible moles and compute counter updates.
   always_comb begin
      round_start   = (mole_prev == '0) && (mole_positions != '0);
      round_end     = (mole_prev != '0) && (mole_positions == '0);
      // The mask belongs to the old round, so it is ignored in a round_start cycle.
      visible_now   = round_start ? mole_positions : (mole_positions & ~hit_mask);
      hits          = '0;
      misses        = '0;
      if (game_enable) begin
         hits   = press & visible_now;
         misses = press & ~visible_now;
      end
      if (score_clear) begin
         hit_mask_next = '0;
      end else if (round_start) begin
         hit_mask_next = hits;
      end else begin
         hit_mask_next = hit_mask | hits;
      end
      hit_cnt    = popcount(MAX_HOLES'(hits));
      miss_cnt   = popcount(MAX_HOLES'(misses));
      esc_cnt    = popcount(MAX_HOLES'(visible_moles));
      score_next = SCORE_WIDTH'(sat_add_sub(int'(score), int'(hit_cnt),
                                            MISS_PENALTY * int'(miss_cnt), MAX_VAL));
      miss_next  = SCORE_WIDTH'(sat_add_sub(int'(miss_count), int'(miss_cnt), 0, MAX_VAL));
      esc_next   = escaped_count;
      if (game_enable && round_end) begin
         esc_next = SCORE_WIDTH'(sat_add_sub(int'(escaped_count), int'(esc_cnt), 0, MAX_VAL));
      end
   end

   // Register round tracking, the mask, the display vector, counters and pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mole_prev     <= '0;
         hit_mask      <= '0;
         visible_moles <= '0;
         score         <= '0;
         miss_count    <= '0;
         escaped_count <= '0;
         hit_pulse     <= 1'b0;
         miss_pulse    <= 1'b0;
      end else begin
         mole_prev     <= mole_positions;
         hit_mask      <= hit_mask_next;
         visible_moles <= mole_positions & ~hit_mask_next;
         if (score_clear) begin
            score         <= '0;
            miss_count    <= '0;
            escaped_count <= '0;
            hit_pulse     <= 1'b0;
            miss_pulse    <= 1'b0;
         end else begin
            score         <= score_next;
            miss_count    <= miss_next;
            escaped_count <= esc_next;
            hit_pulse     <= |hits;
            miss_pulse    <= |misses;
         end
      end
   end

endmodule

// File: tb/tb_whack_scorer.sv
// Directed bench for whack_scorer with a 4-cycle debounce and a 4-bit score.
module tb_whack_scorer;

   localparam int NH = 18;
   localparam int SW = 4;
   localparam int DB = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NH-1:0] mole_positions;
   logic [NH-1:0] buttons;
   logic          game_enable;
   logic          score_clear;
   logic [NH-1:0] visible_moles;
   logic [SW-1:0] score;
   logic [SW-1:0] miss_count;
   logic [SW-1:0] escaped_count;
   logic          hit_pulse;
   logic          miss_pulse;

   int tests = 0;
   int fails = 0;

   whack_scorer #(
      .NUM_HOLES      (NH),
      .SCORE_WIDTH    (SW),
      .DEBOUNCE_CYCLES(DB),
      .MISS_PENALTY   (1)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mole_positions(mole_positions),
      .buttons       (buttons),
      .game_enable   (game_enable),
      .score_clear   (score_clear),
      .visible_moles (visible_moles),
      .score         (score),
      .miss_count    (miss_count),
      .escaped_count (escaped_count),
      .hit_pulse     (hit_pulse),
      .miss_pulse    (miss_pulse)
   );

   // Clock: rising edges at 5, 15, 25 ...; inputs are driven and outputs sampled on falling edges.
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; mole_positions = '0; buttons = '0; game_enable = 1'b1; score_clear = 1'b0;
      tick(2);
      tests++; if (visible_moles !== '0) begin fails++; $display("FAIL reset_visible got %0h exp 0", visible_moles); end
      tests++; if (score !== '0) begin fails++; $display("FAIL reset_score got %0d exp 0", score); end
      tests++; if (miss_count !== '0) begin fails++; $display("FAIL reset_miss got %0d exp 0", miss_count); end
      tests++; if (escaped_count !== '0) begin fails++; $display("FAIL reset_esc got %0d exp 0", escaped_count); end
      tests++; if ({hit_pulse, miss_pulse} !== 2'b00) begin fails++; $display("FAIL reset_pulses got %b exp 00", {hit_pulse, miss_pulse}); end
      rst_n = 1'b1;
      tick(1);
   endtask

   // Hold buttons[2] on a visible mole: hit_pulse exactly 7 edges after the raw rise.
   task automatic test_first_hit;
      mole_positions = 18'h00005;
      tick(1);
      tests++; if (visible_moles !== 18'h00005) begin fails++; $display("FAIL lag_visible got %0h exp 5", visible_moles); end
      buttons = 18'h00004;
      for (int k = 1; k <= 8; k++) begin
         tick(1);
         tests++;
         if (hit_pulse !== (k == 7)) begin fails++; $display("FAIL hit_latency edge %0d got %b exp %b", k, hit_pulse, (k == 7)); end
         if (k == 7) begin
            tests++; if (score !== 4'd1) begin fails++; $display("FAIL hit_score got %0d exp 1", score); end
            tests++; if (visible_moles !== 18'h00001) begin fails++; $display("FAIL hit_visible got %0h exp 1", visible_moles); end
         end
      end
      buttons = '0;
      tick(10);
   endtask

   // Short pulses are filtered; a 5-cycle pulse is one miss; score floors at 0.
   task automatic test_debounce_miss;
      buttons = 18'h00080; tick(1); buttons = '0; tick(10);
      buttons = 18'h00080; tick(3); buttons = '0; tick(10);
      tests++; if (miss_count !== 4'd0) begin fails++; $display("FAIL glitch_miss got %0d exp 0", miss_count); end
      tests++; if (score !== 4'd1) begin fails++; $display("FAIL glitch_score got %0d exp 1", score); end
      buttons = 18'h00080; tick(5); buttons = '0; tick(2);
      tests++; if (miss_pulse !== 1'b1) begin fails++; $display("FAIL pulse5_miss_pulse got %b exp 1", miss_pulse); end
      tests++; if (miss_count !== 4'd1) begin fails++; $display("FAIL pulse5_miss got %0d exp 1", miss_count); end
      tests++; if (score !== 4'd0) begin fails++; $display("FAIL pulse5_score got %0d exp 0", score); end
      tick(1);
      tests++; if (miss_pulse !== 1'b0) begin fails++; $display("FAIL pulse_width got %b exp 0", miss_pulse); end
      tick(10);
      buttons = 18'h00080; tick(7);
      tests++; if (miss_count !== 4'd2) begin fails++; $display("FAIL floor_miss got %0d exp 2", miss_count); end
      tests++; if (score !== 4'd0) begin fails++; $display("FAIL floor_score got %0d exp 0", score); end
      buttons = '0; tick(10);
   endtask

   // End rounds with unhit moles and check escapes; a new round clears the mask.
   task automatic test_escape;
      mole_positions = '0; tick(1);
      tests++; if (escaped_count !== 4'd1) begin fails++; $display("FAIL esc_first got %0d exp 1", escaped_count); end
      mole_positions = 18'h00007; tick(1);
      tests++; if (visible_moles !== 18'h00007) begin fails++; $display("FAIL esc_new_round got %0h exp 7", visible_moles); end
      buttons = 18'h00001; tick(7);
      tests++; if (visible_moles !== 18'h00006) begin fails++; $display("FAIL esc_hit_visible got %0h exp 6", visible_moles); end
      tests++; if (score !== 4'd1) begin fails++; $display("FAIL esc_hit_score got %0d exp 1", score); end
      buttons = '0; tick(10);
      mole_positions = '0; tick(1);
      tests++; if (escaped_count !== 4'd3) begin fails++; $display("FAIL esc_count got %0d exp 3", escaped_count); end
      mole_positions = 18'h00001; tick(1);
      tests++; if (visible_moles !== 18'h00001) begin fails++; $display("FAIL esc_restore got %0h exp 1", visible_moles); end
   endtask

   // Hit on hole 1 and miss on hole 5 in the same cycle.
   task automatic test_hit_and_miss;
      mole_positions = 18'h00003; tick(1);
      buttons = 18'h00022; tick(7);
      tests++; if ({hit_pulse, miss_pulse} !== 2'b11) begin fails++; $display("FAIL hm_pulses got %b exp 11", {hit_pulse, miss_pulse}); end
      tests++; if (score !== 4'd1) begin fails++; $display("FAIL hm_score got %0d exp 1", score); end
      tests++; if (miss_count !== 4'd3) begin fails++; $display("FAIL hm_miss got %0d exp 3", miss_count); end
      tests++; if (visible_moles !== 18'h00001) begin fails++; $display("FAIL hm_visible got %0h exp 1", visible_moles); end
      buttons = '0; tick(10);
   endtask

   // Twenty hits across rounds saturate the score; clear beats a simultaneous hit.
   task automatic test_saturate_clear;
      int exp_score;
      exp_score = 1;
      mole_positions = '0; tick(1);
      tests++; if (escaped_count !== 4'd4) begin fails++; $display("FAIL sat_esc got %0d exp 4", escaped_count); end
      for (int i = 0; i < 20; i++) begin
         mole_positions = 18'h00001; tick(1);
         buttons = 18'h00001; tick(7);
         exp_score = (exp_score < 15) ? exp_score + 1 : 15;
         tests++; if (score !== SW'(exp_score)) begin fails++; $display("FAIL sat_score hit %0d got %0d exp %0d", i, score, exp_score); end
         buttons = '0; tick(10);
         mole_positions = '0; tick(1);
      end
      tests++; if (escaped_count !== 4'd4) begin fails++; $display("FAIL sat_esc_hold got %0d exp 4", escaped_count); end
      mole_positions = 18'h00001; tick(1);
      buttons = 18'h00001; tick(6);
      score_clear = 1'b1; tick(1);
      tests++; if ({score, miss_count, escaped_count} !== 12'h000) begin fails++; $display("FAIL clear_counters got %0h exp 0", {score, miss_count, escaped_count}); end
      tests++; if (visible_moles !== 18'h00001) begin fails++; $display("FAIL clear_visible got %0h exp 1", visible_moles); end
      score_clear = 1'b0; buttons = '0; tick(3);
      tests++; if (score !== 4'd0) begin fails++; $display("FAIL clear_no_inc got %0d exp 0", score); end
      tick(8);
   endtask

   // Reset in the middle of a debounce; the held button presses 7 edges after release.
   task automatic test_reset_mid;
      buttons = 18'h00008; tick(3);
      rst_n = 1'b0; tick(1);
      tests++; if ({visible_moles, score, miss_count, escaped_count, hit_pulse, miss_pulse} !== '0) begin
         fails++; $display("FAIL midrst_outputs got %0h exp 0", {visible_moles, score, miss_count, escaped_count, hit_pulse, miss_pulse});
      end
      rst_n = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick(1);
         tests++;
         if (miss_pulse !== (k == 7)) begin fails++; $display("FAIL midrst_latency edge %0d got %b exp %b", k, miss_pulse, (k == 7)); end
      end
      tests++; if (miss_count !== 4'd1) begin fails++; $display("FAIL midrst_miss got %0d exp 1", miss_count); end
      tests++; if (visible_moles !== 18'h00001) begin fails++; $display("FAIL midrst_visible got %0h exp 1", visible_moles); end
      buttons = '0; tick(10);
   endtask

   // With the game disabled a press on a visible mole does nothing.
   task automatic test_disable;
      game_enable = 1'b0;
      buttons = 18'h00001; tick(7);
      tests++; if ({hit_pulse, miss_pulse} !== 2'b00) begin fails++; $display("FAIL dis_pulses got %b exp 00", {hit_pulse, miss_pulse}); end
      tests++; if (score !== 4'd0) begin fails++; $display("FAIL dis_score got %0d exp 0", score); end
      tests++; if (visible_moles !== 18'h00001) begin fails++; $display("FAIL dis_visible got %0h exp 1", visible_moles); end
      buttons = '0; tick(10);
      game_enable = 1'b1;
   endtask

   initial begin
      test_reset;
      test_first_hit;
      test_debounce_miss;
      test_escape;
      test_hit_and_miss;
      test_saturate_clear;
      test_reset_mid;
      test_disable;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Guard against a stalled run.
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

endmodule
